// File: rtl/sd_block_writer.sv
// sd_block_writer: SPI-mode CMD24 single-block write engine; define SD_WRITE_CRC16_EN to send a real CRC16 instead of FF FF
module sd_block_writer #(
    parameter int R1_TIMEOUT_BYTES   = 8,
    parameter int BUSY_TIMEOUT_BYTES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic        write_start,
    input  logic [31:0] addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        mosi,
    input  logic        miso,
    output logic        cs,
    output logic        busy,
    output logic        write_done,
    output logic [2:0]  err_code
);
    typedef enum logic [3:0] {IDLE, CMD, R1, GAP, TOKEN, DATA, CRC, RESP, BUSY, FINISH} state_t;

    state_t      state, state_n;
    logic [7:0]  tx_sr, tx_n, rx_byte, next_byte, hold_q, crc_hi, crc_lo;
    logic [6:0]  rx_sr;
    logic [2:0]  bit_cnt, err_n;
    logic [15:0] byte_cnt;
    logic [9:0]  req_cnt;
    logic [31:0] addr_q;
    logic        hold_full, byte_end, xfer, avail, take, done_n;

    assign byte_end  = bit_cnt == 3'd7;
    assign rx_byte   = {rx_sr, miso};
    assign xfer      = wr_valid && wr_ready;
    assign avail     = hold_full || xfer;
    assign next_byte = hold_full ? hold_q : wr_data;
    assign wr_ready  = !hold_full && (state == TOKEN || state == DATA) && req_cnt != 10'd512;
    assign mosi      = tx_sr[7];
    assign cs        = state == IDLE || state == FINISH;
    assign busy      = state != IDLE;

`ifdef SD_WRITE_CRC16_EN
    logic [15:0] crc, crc_n;
    assign crc_n  = {crc[14:0], 1'b0} ^ ((crc[15] ^ tx_sr[7]) ? 16'h1021 : 16'h0000);
    assign crc_hi = crc_n[15:8];
    assign crc_lo = crc[7:0];
    // CRC16-CCITT over payload bits as they leave on mosi; frozen after DATA
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) crc <= '0;
        else if (state == IDLE) crc <= '0;
        else if (state == DATA) crc <= crc_n;
    end
`else
    assign crc_hi = 8'hFF;
    assign crc_lo = 8'hFF;
`endif

    // byte-boundary sequencing: next state, next outgoing byte, error and done
    always_comb begin
        state_n = state;
        err_n   = err_code;
        tx_n    = {tx_sr[6:0], 1'b1};
        take    = 1'b0;
        done_n  = 1'b0;
        if (state == IDLE) begin
            tx_n = 8'hFF;
            if (write_start && init_done) begin
                state_n = CMD;
                err_n   = 3'd0;
                tx_n    = 8'h58;
            end
        end else if (byte_end) begin
            tx_n = 8'hFF;
            case (state)
                CMD: begin
                    tx_n    = addr_q[31:24];
                    state_n = byte_cnt == 16'd5 ? R1 : CMD;
                end
                R1: if (!rx_byte[7]) begin
                    state_n = rx_byte == 8'h00 ? GAP : FINISH;
                    err_n   = rx_byte == 8'h00 ? 3'd0 : 3'd2;
                end else if (byte_cnt == 16'(R1_TIMEOUT_BYTES - 1)) begin
                    state_n = FINISH;
                    err_n   = 3'd1;
                end
                GAP: begin
                    state_n = TOKEN;
                    tx_n    = 8'hFE;
                end
                TOKEN, DATA: if (state == DATA && byte_cnt == 16'd511) begin
                    state_n = CRC;
                    tx_n    = crc_hi;
                end else if (avail) begin
                    state_n = DATA;
                    tx_n    = next_byte;
                    take    = 1'b1;
                end else begin
                    state_n = FINISH;
                    err_n   = 3'd6;
                end
                CRC: begin
                    state_n = byte_cnt == 16'd1 ? RESP : CRC;
                    tx_n    = byte_cnt == 16'd1 ? 8'hFF : crc_lo;
                end
                RESP: if (!rx_byte[4] && rx_byte[0]) begin
                    state_n = rx_byte[3:1] == 3'b010 ? BUSY : FINISH;
                    err_n   = rx_byte[3:1] == 3'b010 ? 3'd0 : rx_byte[3:1] == 3'b101 ? 3'd3 : 3'd4;
                end else if (byte_cnt == 16'd7) begin
                    state_n = FINISH;
                    err_n   = 3'd4;
                end
                BUSY: if (rx_byte != 8'h00) begin
                    state_n = FINISH;
                end else if (byte_cnt == 16'(BUSY_TIMEOUT_BYTES - 1)) begin
                    state_n = FINISH;
                    err_n   = 3'd5;
                end
                FINISH: begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end

    // shift registers, counters, address latch and the one-byte payload holding register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_sr      <= 8'hFF;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            req_cnt    <= '0;
            addr_q     <= '0;
            hold_q     <= '0;
            hold_full  <= 1'b0;
            err_code   <= '0;
            write_done <= 1'b0;
        end else begin
            tx_sr      <= tx_n;
            rx_sr      <= rx_byte[6:0];
            err_code   <= err_n;
            write_done <= done_n;
            bit_cnt    <= state == IDLE ? 3'd0 : bit_cnt + 3'd1;
            byte_cnt   <= state_n != state ? 16'd0 : byte_end ? byte_cnt + 16'd1 : byte_cnt;
            if (state == IDLE) begin
                addr_q    <= addr;
                hold_full <= 1'b0;
                req_cnt   <= '0;
            end else begin
                if (state == CMD && byte_end) addr_q <= {addr_q[23:0], 8'hFF};
                if (take) hold_full <= 1'b0;
                else if (xfer) begin
                    hold_q    <= wr_data;
                    hold_full <= 1'b1;
                end
                if (xfer) req_cnt <= req_cnt + 10'd1;
            end
        end
    end
endmodule

// File: tb/tb_sd_block_writer.sv
// tb_sd_block_writer: randomized bench with a byte-level SD card model and transaction-level reference
`timescale 1ns/1ps
module tb_sd_block_writer;
    localparam int R1T = 8;
    localparam int BT  = 16;

    logic        clk = 1'b0, reset = 1'b0, init_done = 1'b0, write_start = 1'b0, wr_valid = 1'b0, miso = 1'b1;
    logic [31:0] addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready, mosi, cs, busy, write_done;
    logic [2:0]  err_code;
    int          n_vec = 0, n_err = 0;

    sd_block_writer #(.R1_TIMEOUT_BYTES(R1T), .BUSY_TIMEOUT_BYTES(BT)) dut (
        .clk(clk), .reset(reset), .init_done(init_done), .write_start(write_start), .addr(addr),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .mosi(mosi), .miso(miso),
        .cs(cs), .busy(busy), .write_done(write_done), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // card configuration and observations
    int         c_r1_dly, c_resp_dly, c_busy, stop_at = 1000;
    logic [7:0] c_r1, c_tok;
    logic [7:0] payload [512];
    logic [7:0] cmd_q[$], data_q[$], crc_q[$];

    typedef enum {P_CMD, P_R1, P_TOK, P_DATA, P_CRC, P_RESP, P_BUSY} phase_t;
    phase_t     ph = P_CMD;
    int         bitpos = 0, cnt = 0;
    logic [7:0] sh = '0, ob = 8'hFF;

    // SD card: samples DI and drives DO mid-cycle, one byte slot at a time
    always @(negedge clk) begin
        if (!busy) begin
            ph = P_CMD; bitpos = 0; cnt = 0; miso = 1'b1;
        end else if (cs) begin
            miso = 1'b1;
        end else begin
            if (bitpos == 0)
                ob = ph == P_R1   ? (cnt == c_r1_dly ? c_r1 : 8'hFF) :
                     ph == P_RESP ? (cnt == c_resp_dly ? c_tok : 8'hFF) :
                     ph == P_BUSY ? (cnt < c_busy ? 8'h00 : 8'hFF) : 8'hFF;
            miso = ob[7 - bitpos];
            sh = {sh[6:0], mosi};
            bitpos++;
            if (bitpos == 8) begin
                bitpos = 0;
                case (ph)
                    P_CMD:  begin cmd_q.push_back(sh); if (cmd_q.size() == 6) begin ph = P_R1; cnt = 0; end end
                    P_R1:   if (cnt == c_r1_dly) ph = P_TOK; else cnt++;
                    P_TOK:  if (sh == 8'hFE) ph = P_DATA;
                    P_DATA: begin data_q.push_back(sh); if (data_q.size() == 512) ph = P_CRC; end
                    P_CRC:  begin crc_q.push_back(sh); if (crc_q.size() == 2) begin ph = P_RESP; cnt = 0; end end
                    P_RESP: if (cnt == c_resp_dly) begin ph = P_BUSY; cnt = 0; end else cnt++;
                    P_BUSY: cnt++;
                    default: ;
                endcase
            end
        end
    end

    // payload source with short random stalls; stops offering at stop_at transfers
    int tx_i = 0, lowrun = 0;
    always @(negedge clk) begin
        if (tx_i != stop_at && (lowrun >= 3 || $urandom_range(3) != 0)) begin
            wr_valid = 1'b1; lowrun = 0;
        end else begin
            wr_valid = 1'b0; lowrun++;
        end
        wr_data = payload[tx_i % 512];
    end

    // accepted-transfer counter, restarted at each accepted start
    always @(posedge clk) begin
        if (reset && !busy && write_start && init_done) tx_i <= 0;
        else if (wr_valid && wr_ready) tx_i <= tx_i + 1;
    end

    function automatic logic [15:0] crc_model();
        logic [15:0] c;
        logic        fb;
        c = '0;
        for (int i = 0; i < 512; i++)
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ payload[i][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        return c;
    endfunction

    // reference: byte slots from start to write_done, error code and accepted transfers
    task automatic expect_txn(output int slots, output int err, output int xfers);
        int s;
        logic [2:0] st;
        s = 6; xfers = 0;
        if (c_r1_dly >= R1T) begin slots = s + R1T + 1; err = 1; return; end
        s += c_r1_dly + 1;
        if (c_r1 != 8'h00) begin slots = s + 1; err = 2; return; end
        s += 2;
        if (stop_at < 512) begin slots = s + stop_at + 1; err = 6; xfers = stop_at; return; end
        s += 514; xfers = 512;
        if (c_resp_dly >= 8) begin slots = s + 9; err = 4; return; end
        s += c_resp_dly + 1;
        st = c_tok[3:1];
        if (st != 3'b010) begin slots = s + 1; err = st == 3'b101 ? 3 : 4; return; end
        if (c_busy >= BT) begin slots = s + BT + 1; err = 5; return; end
        slots = s + c_busy + 2; err = 0;
    endtask

    task automatic run_txn(input string tag, input logic [31:0] a, input int r1d, input logic [7:0] r1,
                           input int rd, input logic [7:0] tok, input int bz, input int stp,
                           input int pmode, input int crc_exp, input bit poke);
        int slots, err, xf, cyc, bad;
        logic [47:0] cmd;
        logic [15:0] exp_crc, got_crc;
        c_r1_dly = r1d; c_r1 = r1; c_resp_dly = rd; c_tok = tok; c_busy = bz; stop_at = stp;
        for (int i = 0; i < 512; i++)
            payload[i] = pmode == 0 ? 8'(i) : pmode == 1 ? 8'h00 : pmode == 2 ? 8'hFF : 8'($urandom);
`ifdef SD_WRITE_CRC16_EN
        exp_crc = crc_exp < 0 ? crc_model() : 16'(crc_exp);
`else
        exp_crc = 16'hFFFF;
`endif
        cmd_q.delete(); data_q.delete(); crc_q.delete();
        expect_txn(slots, err, xf);
        @(negedge clk); addr = a; write_start = 1'b1;
        @(posedge clk); #1; write_start = 1'b0;
        check({tag, ".start"}, {busy, cs, mosi}, 3'b100);
        cyc = 0;
        while (cyc < 6000) begin
            if (poke && cyc == 20) begin write_start = 1'b1; addr = ~a; end
            if (poke && cyc == 21) write_start = 1'b0;
            @(posedge clk); #1; cyc++;
            if (write_done) break;
        end
        check({tag, ".cycles"}, cyc, 8 * slots);
        check({tag, ".err"}, err_code, err);
        check({tag, ".idle"}, {cs, busy}, 2'b10);
        cmd = '0;
        foreach (cmd_q[i]) if (i < 6) cmd = {cmd[39:0], cmd_q[i]};
        check({tag, ".cmd"}, {16'(cmd_q.size()), cmd}, {16'd6, 8'h58, a, 8'hFF});
        check({tag, ".xfers"}, tx_i, xf);
        if (xf == 512) begin
            bad = 0;
            for (int i = 0; i < data_q.size() && i < 512; i++) if (data_q[i] !== payload[i]) bad++;
            check({tag, ".data"}, {32'(data_q.size()), 32'(bad)}, {32'd512, 32'd0});
            got_crc = crc_q.size() == 2 ? {crc_q[0], crc_q[1]} : 16'h0;
            check({tag, ".crc"}, {8'(crc_q.size()), got_crc}, {8'd2, exp_crc});
        end
        @(posedge clk); #1;
        check({tag, ".pulse"}, {write_done, err_code}, {1'b0, 3'(err)});
        addr = a;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        repeat (3) @(posedge clk); #1;
        check("reset", {cs, mosi, wr_ready, busy, write_done, err_code}, {5'b11000, 3'd0});
        @(negedge clk); reset = 1'b1;
        @(negedge clk); write_start = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("no_init", {busy, cs}, 2'b01);
        write_start = 1'b0;
        init_done = 1'b1;
        run_txn("happy",     32'h0000_0200, 0, 8'h00, 0, 8'hE5, 3, 1000, 0, -1, 1'b0);
        run_txn("minimum",   $urandom,      0, 8'h00, 0, 8'hE5, 0, 1000, 3, -1, 1'b0);
        run_txn("r1_none",   $urandom,     99, 8'h00, 0, 8'hE5, 0, 1000, 3, -1, 1'b0);
        run_txn("r1_bad",    $urandom,      2, 8'h04, 0, 8'hE5, 0, 1000, 3, -1, 1'b0);
        run_txn("resp_crc",  $urandom,      0, 8'h00, 1, 8'h0B, 0, 1000, 3, -1, 1'b0);
        run_txn("resp_wr",   $urandom,      1, 8'h00, 0, 8'h0D, 0, 1000, 3, -1, 1'b0);
        run_txn("after_err", $urandom,      0, 8'h00, 0, 8'hE5, 2, 1000, 3, -1, 1'b0);
        run_txn("underflow", $urandom,      0, 8'h00, 0, 8'hE5, 0,  100, 3, -1, 1'b0);
        run_txn("crc_zero",  $urandom,      0, 8'h00, 0, 8'hE5, 0, 1000, 1, 16'h0000, 1'b0);
        run_txn("crc_ones",  $urandom,      0, 8'h00, 0, 8'hE5, 0, 1000, 2, 16'h7FA1, 1'b0);
        run_txn("resp_none", $urandom,      0, 8'h00, 20, 8'hE5, 0, 1000, 3, -1, 1'b0);
        run_txn("busy_to",   $urandom,      0, 8'h00, 0, 8'hE5, 30, 1000, 3, -1, 1'b0);
        for (int k = 0; k < 3; k++)
            run_txn("random", $urandom, $urandom_range(0, 7), 8'h00, $urandom_range(0, 7), 8'hE5,
                    $urandom_range(0, 6), 1000, 3, -1, 1'b1);
        cmd_q.delete(); data_q.delete(); crc_q.delete(); stop_at = 1000;
        @(negedge clk); write_start = 1'b1;
        @(posedge clk); #1; write_start = 1'b0;
        repeat (200) @(posedge clk); #1;
        check("mid.in_data", {busy, cs}, 2'b10);
        reset = 1'b0;
        @(negedge clk);
        check("mid.reset", {cs, mosi, busy, write_done}, 4'b1100);
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (write_done) seen = 1; end
        check("mid.no_done", seen, 0);
        @(negedge clk); reset = 1'b1;
        run_txn("post_rst", $urandom, 0, 8'h00, 0, 8'hE5, 1, 1000, 3, -1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sd_block_writer.md
# sd_block_writer

SPI-mode single-block write engine for the SD card path: the transmit-direction counterpart to the block-read state machine. After card initialisation completes, it issues CMD24 to a 32-bit address, streams exactly 512 bytes from a byte handshake into the card, checks the data-response token, and waits out the card's busy period. It runs in the SD clock domain alongside the read controller and shares the card's CMD/DAT lines through the top-level mux.

## Interface
- `R1_TIMEOUT_BYTES`, default 8: maximum bytes polled for the CMD24 R1 response.
- `BUSY_TIMEOUT_BYTES`, default 65535: maximum bytes polled while the card holds MISO low after data.
- `clk` in 1: SD clock. One clock; the top level drives the card clock as `~clk`.
- `reset` in 1: asynchronous, active-low reset.
- `init_done` in 1: card initialised. Starts are ignored while this is low.
- `write_start` in 1: level or pulse. Sampled only in IDLE.
- `addr` in 32: CMD24 argument, passed verbatim. Latched at the accepted start.
- `wr_data` in 8: payload byte.
- `wr_valid` in 1: `wr_data` is valid.
- `wr_ready` out 1: the block accepts `wr_data` in this cycle.
- `mosi` out 1: to card DI (`SD_CMD`).
- `miso` in 1: from card DO (`SD_DAT[0]`).
- `cs` out 1: to card CS (`SD_DAT[3]`), active-low.
- `busy` out 1: a transaction is in progress.
- `write_done` out 1: one-cycle pulse at the end of every accepted transaction, whether it succeeds or fails.
- `err_code` out 3: 0 ok, 1 R1 timeout, 2 R1 nonzero, 3 data rejected (CRC), 4 write error, 5 busy timeout, 6 payload underflow.

## Operation
- All bytes go MSB first. `mosi` changes after the rising edge of `clk`. `miso` is sampled on the rising edge. A byte takes 8 clocks.
- States and transitions:
  - IDLE: `cs`=1, `mosi`=1. If `write_start & init_done`, latch `addr`, clear `err_code`, go to CMD.
  - CMD: `cs`=0. Send 0x58, addr[31:24], addr[23:16], addr[15:8], addr[7:0], 0xFF (6 bytes, 48 clocks).
  - R1: send 0xFF and capture each byte.
    - First byte with bit7=0 is R1. R1 == 0x00 goes to GAP. Any other value ends with err 2.
    - No response after `R1_TIMEOUT_BYTES` bytes ends with err 1.
  - GAP: send one 0xFF byte.
  - TOKEN: send 0xFE.
  - DATA: send 512 payload bytes. A 10-bit counter runs 0..511.
  - CRC: send 2 CRC bytes (see Configuration).
  - RESP: send 0xFF and capture each byte. The first byte matching xxx0sss1 is the response token; its bits[3:1] are the status.
    - Status 010 goes to BUSY.
    - Status 101 ends with err 3.
    - Status 110 ends with err 4.
    - Any other status ends with err 4.
    - No token within 8 bytes ends with err 4.
  - BUSY: send 0xFF. The first byte captured as nonzero goes to FINISH. `BUSY_TIMEOUT_BYTES` bytes without one ends with err 5.
  - FINISH: `cs`=1. Send one 0xFF byte (8 clocks), then pulse `write_done` and return to IDLE.
- Every error path takes the FINISH path.
- Payload handshake: a one-byte holding register.
  - `wr_ready` = holding register empty and the state is TOKEN or DATA with bytes still unrequested. A transfer happens when `wr_valid & wr_ready`.
  - At every DATA byte boundary the holding register must be full. If it is empty, stop sending data, take FINISH with err 6, and accept no further bytes.
- Exactly 512 transfers are accepted per transaction, never more.
- `busy` = 1 in every state except IDLE.
- `write_start` while `busy` is ignored.
- `err_code` holds its value from `write_done` until the next accepted start.

## Timing
- Reset values (asynchronous): state IDLE, `cs`=1, `mosi`=1, `wr_ready`=0, `busy`=0, `write_done`=0, `err_code`=0, counters 0.
- Reset mid-transaction aborts immediately. `write_done` is not pulsed.
- Start accepted at edge N: `busy`=1 and `cs`=0 from N+1. The first command bit is on `mosi` at N+1.
- The first `wr_ready` is asserted in the first TOKEN cycle, so byte 0 is prefetched before DATA begins.
- Minimum successful transaction with R1 on the first poll, token on the first poll, and one busy byte: (6+1+1+1+512+2+1+1+1)×8 = 4208 clocks from start to the `write_done` pulse.

## Configuration
- `SD_WRITE_CRC16_EN` defined: compute CRC16-CCITT (polynomial 0x1021, init 0x0000) bit-serially over the 512 payload bytes as they shift out, and send it high byte first.
- `SD_WRITE_CRC16_EN` undefined: send 0xFF, 0xFF as the CRC bytes. SPI mode ignores CRC unless CMD59 enabled it. No CRC logic is instantiated.

## Test plan
- Happy path, card model: R1=0x00, token 0xE5, busy for 3 bytes. With addr=0x00000200 and payload i&0xFF, the card model receives 58 00 00 02 00 FF; `write_done` pulses with err 0; `cs` returns to 1.
- R1 never arrives (`miso` stuck 1): err 1 after 8 poll bytes. Same run with R1=0x04: err 2.
- Data response 0x0B: err 3. Data response 0x0D: err 4. In both cases `cs`=1 afterwards and the next start works normally.
- `wr_valid` dropped at byte 100 for longer than 8 clocks: err 6; exactly 100 transfers accepted.
- With `SD_WRITE_CRC16_EN` and an all-0x00 payload, CRC bytes are 00 00. With a payload of 512 × 0xFF, CRC bytes are 7F A1.
- `reset` asserted during DATA: the next cycle shows `cs`=1, `mosi`=1, `busy`=0, no `write_done`. A fresh start after release completes with err 0.
